moving_average_var: RTL and testbench

Parametrised boxcar moving-average filter with a run-time selectable power-of-two window. It is the next generation of the single-window averager in the TinyTapeout top level. The sample stream arrives with a valid strobe, and a registered average is produced one cycle later. A window-filled flag lets the display and seven-segment logic ignore warm-up values.

---
 rtl/moving_average_var.sv | 97 +++++++++
 tb/tb_moving_average_var.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/moving_average_var.sv
// Boxcar moving-average filter with a run-time power-of-two window.
// One registered average per accepted sample; out_full marks a primed window.
module moving_average_var #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [2:0]       win_sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_avg,
  output logic             out_full
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam int FW    = LOG2_DEPTH + 1;
  localparam logic [2:0] WS_MAX = 3'(LOG2_DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [LOG2_DEPTH-1:0]       wptr, old_idx, widx;
  logic [FW-1:0]               fill, fill_nxt, win;
  logic [SW-1:0]               sum, sum_nxt, sub;
  logic [2:0]                  ws, ws_q;
  logic [WIDTH-1:0]            avg_nxt;
  logic                        restart, full_nxt;

  always_comb begin
    ws      = (win_sel > WS_MAX) ? WS_MAX : win_sel;
    win     = FW'(1) << ws;
    restart = (ws != ws_q);
    // For W == DEPTH the truncated offset is 0, so the oldest slot is wptr itself.
    old_idx = wptr - win[LOG2_DEPTH-1:0];
    sub     = (fill >= win) ? SW'(mem[old_idx]) : '0;
    if (restart) begin
      sum_nxt  = SW'(in_data);
      fill_nxt = FW'(1);
      widx     = '0;
    end else begin
      sum_nxt  = sum + SW'(in_data) - sub;
      fill_nxt = (fill == FW'(DEPTH)) ? fill : fill + FW'(1);
      widx     = wptr;
    end
    avg_nxt  = WIDTH'(sum_nxt >> ws);
    full_nxt = (fill_nxt >= win);
  end

  // Sample storage is never reset; fill gates which entries are meaningful.
  always_ff @(posedge clk) begin
    if (in_valid && !clear) mem[widx] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      fill      <= '0;
      wptr      <= '0;
      ws_q      <= '0;
      out_valid <= 1'b0;
      out_avg   <= '0;
      out_full  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        sum      <= '0;
        fill     <= '0;
        wptr     <= '0;
        ws_q     <= ws;
        out_avg  <= '0;
        out_full <= 1'b0;
      end else if (restart) begin
        ws_q <= ws;
        if (in_valid) begin
          sum       <= sum_nxt;
          fill      <= fill_nxt;
          wptr      <= LOG2_DEPTH'(1);
          out_valid <= 1'b1;
          out_avg   <= avg_nxt;
          out_full  <= full_nxt;
        end else begin
          sum  <= '0;
          fill <= '0;
          wptr <= '0;
        end
      end else if (in_valid) begin
        sum       <= sum_nxt;
        fill      <= fill_nxt;
        wptr      <= wptr + LOG2_DEPTH'(1);
        out_valid <= 1'b1;
        out_avg   <= avg_nxt;
        out_full  <= full_nxt;
      end
    end
  end
endmodule

// File: tb/tb_moving_average_var.sv
// Self-checking bench for moving_average_var (WIDTH=8, LOG2_DEPTH=3).
// Expected averages are queued as samples are driven and popped as outputs appear.
module tb_moving_average_var;
  logic       clk, rst, clear, in_valid, out_valid, out_full;
  logic [2:0] win_sel;
  logic [7:0] in_data, out_avg;

  typedef struct { logic [7:0] avg; logic full; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  moving_average_var #(.WIDTH(8), .LOG2_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .win_sel(win_sel), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_avg(out_avg), .out_full(out_full));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs before the posedge, return at the following negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] ws, input logic clr);
    in_valid = v; in_data = d; win_sel = ws; clear = clr;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; clear = 0;
  endtask

  function automatic exp_t mk(input int avg, input logic full);
    exp_t e;
    e.avg = 8'(avg); e.full = full;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    int warm[8] = '{12, 25, 37, 50, 62, 75, 87, 100};
    int post[4] = '{1, 2, 3, 4};
    rst = 1; clear = 0; in_valid = 0; in_data = 0; win_sel = 0;
    #3;
    checks++;
    if (out_valid !== 0 || out_avg !== 0 || out_full !== 0) begin
      failures++; $display("FAIL reset_state valid=%0b avg=%0d full=%0b expected 0/0/0", out_valid, out_avg, out_full);
    end
    @(negedge clk); rst = 0;
    for (int i = 0; i < 8; i++) begin
      q.push_back(mk(warm[i], i == 7));
      step(1, 100, 3, 0);
      e = q.pop_front();
      checks++;
      if (out_valid !== 1 || out_avg !== e.avg || out_full !== e.full) begin
        failures++; $display("FAIL reset_warm[%0d] valid=%0b avg=%0d full=%0b expected 1/%0d/%0b", i, out_valid, out_avg, out_full, e.avg, e.full);
      end
    end
    #1 rst = 1;
    #1;
    checks++;
    if (out_valid !== 0 || out_avg !== 0 || out_full !== 0) begin
      failures++; $display("FAIL reset_async valid=%0b avg=%0d full=%0b expected 0/0/0", out_valid, out_avg, out_full);
    end
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(post[i], i == 3));
      step(1, 4, 2, 0);
      e = q.pop_front();
      checks++;
      if (out_valid !== 1 || out_avg !== e.avg || out_full !== e.full) begin
        failures++; $display("FAIL reset_post[%0d] valid=%0b avg=%0d full=%0b expected 1/%0d/%0b", i, out_valid, out_avg, out_full, e.avg, e.full);
      end
    end
  endtask

  task automatic test_basic_window();
    exp_t e;
    int din[5] = '{4, 8, 12, 16, 20};
    int avg[5] = '{1, 3, 6, 10, 14};
    step(0, 0, 2, 1);
    checks++;
    if (out_valid !== 0 || out_avg !== 0 || out_full !== 0) begin
      failures++; $display("FAIL basic_clear valid=%0b avg=%0d full=%0b expected 0/0/0", out_valid, out_avg, out_full);
    end
    for (int i = 0; i < 5; i++) begin
      q.push_back(mk(avg[i], i >= 3));
      step(1, 8'(din[i]), 2, 0);
      e = q.pop_front();
      checks++;
      if (out_valid !== 1 || out_avg !== e.avg || out_full !== e.full) begin
        failures++; $display("FAIL basic[%0d] valid=%0b avg=%0d full=%0b expected 1/%0d/%0b", i, out_valid, out_avg, out_full, e.avg, e.full);
      end
    end
    step(0, 0, 2, 0);
    checks++;
    if (out_valid !== 0 || out_avg !== 14 || out_full !== 1) begin
      failures++; $display("FAIL basic_idle valid=%0b avg=%0d full=%0b expected 0/14/1", out_valid, out_avg, out_full);
    end
  endtask

  task automatic test_extremes_wrap();
    exp_t e;
    int up[8] = '{31, 63, 95, 127, 159, 191, 223, 255};
    int dn[8] = '{223, 191, 159, 127, 95, 63, 31, 0};
    step(0, 0, 3, 1);
    for (int i = 0; i < 16; i++) begin
      q.push_back(i < 8 ? mk(up[i], i == 7) : mk(dn[i-8], 1));
      step(1, i < 8 ? 8'd255 : 8'd0, 3, 0);
      e = q.pop_front();
      checks++;
      if (out_valid !== 1 || out_avg !== e.avg || out_full !== e.full) begin
        failures++; $display("FAIL extremes[%0d] valid=%0b avg=%0d full=%0b expected 1/%0d/%0b", i, out_valid, out_avg, out_full, e.avg, e.full);
      end
    end
  endtask

  task automatic test_window_change();
    exp_t e;
    step(0, 0, 2, 1);
    for (int i = 0; i < 6; i++) begin
      q.push_back(i < 4 ? mk(i + 1, i == 3) : (i == 4 ? mk(5, 0) : mk(15, 1)));
      step(1, i < 4 ? 8'd4 : (i == 4 ? 8'd10 : 8'd20), i < 4 ? 3'd2 : 3'd1, 0);
      e = q.pop_front();
      checks++;
      if (out_valid !== 1 || out_avg !== e.avg || out_full !== e.full) begin
        failures++; $display("FAIL winchg[%0d] valid=%0b avg=%0d full=%0b expected 1/%0d/%0b", i, out_valid, out_avg, out_full, e.avg, e.full);
      end
    end
  endtask

  task automatic test_clear_collision();
    exp_t e;
    step(1, 99, 2, 1);
    checks++;
    if (out_valid !== 0 || out_avg !== 0 || out_full !== 0) begin
      failures++; $display("FAIL clear_collide valid=%0b avg=%0d full=%0b expected 0/0/0", out_valid, out_avg, out_full);
    end
    q.push_back(mk(2, 0));
    step(1, 8, 2, 0);
    e = q.pop_front();
    checks++;
    if (out_valid !== 1 || out_avg !== e.avg || out_full !== e.full) begin
      failures++; $display("FAIL clear_next valid=%0b avg=%0d full=%0b expected 1/%0d/%0b", out_valid, out_avg, out_full, e.avg, e.full);
    end
  endtask

  task automatic test_gaps_clamp();
    exp_t e, last;
    int hist[$];
    int s, d;
    step(0, 0, 7, 1);
    last = mk(0, 0);
    for (int n = 1; n <= 12; n++) begin
      d = int'($urandom_range(0, 255));
      hist.push_back(d);
      s = 0;
      for (int k = (n > 8 ? n - 8 : 0); k < n; k++) s += hist[k];
      q.push_back(mk(s / 8, n >= 8));
      step(1, 8'(d), 7, 0);
      e = q.pop_front();
      checks++;
      if (out_valid !== 1 || out_avg !== e.avg || out_full !== e.full) begin
        failures++; $display("FAIL gaps[%0d] valid=%0b avg=%0d full=%0b expected 1/%0d/%0b", n, out_valid, out_avg, out_full, e.avg, e.full);
      end
      last = e;
      step(0, 8'($urandom_range(0, 255)), 7, 0);
      checks++;
      if (out_valid !== 0 || out_avg !== last.avg || out_full !== last.full) begin
        failures++; $display("FAIL gap_idle[%0d] valid=%0b avg=%0d full=%0b expected 0/%0d/%0b", n, out_valid, out_avg, out_full, last.avg, last.full);
      end
    end
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 255 : int'($urandom_range(0, 255));
      q.push_back(mk(d, 1));
      step(1, 8'(d), 0, 0);
      e = q.pop_front();
      checks++;
      if (out_valid !== 1 || out_avg !== e.avg || out_full !== e.full) begin
        failures++; $display("FAIL passthru[%0d] valid=%0b avg=%0d full=%0b expected 1/%0d/%0b", i, out_valid, out_avg, out_full, e.avg, e.full);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_extremes_wrap();
    test_window_change();
    test_clear_collision();
    test_gaps_clamp();
    checks++;
    if (q.size() !== 0) begin
      failures++; $display("FAIL scoreboard_drain left=%0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
